// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: op-code constants,
// FSM state encoding, and the per-op hold-count helper.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns k-1, where k is the number of EXEC cycles the operands are held.
  function automatic logic [3:0] hold_count(input logic [3:0] sel,
                                            input logic [3:0] mul_m1,
                                            input logic [3:0] div_m1);
    if (sel == OP_MUL)      return mul_m1;
    else if (sel == OP_DIV) return div_m1;
    else                    return 4'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin arbiter: on contention the port that did not win
// last time is chosen. Purely combinational.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  always_comb begin
    grant_valid = valid0 | valid1;
    grant       = 1'b0;
    if (valid0 && valid1) grant = ~last_grant;
    else if (valid1)      grant = 1'b1;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer in front of a shared combinational ALU: arbitrates two requesters,
// holds registered operands for an op-dependent number of cycles, then pulses
// the result back to the winning requester.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high; ready is only raised in IDLE for the granted port.
// Responses are a one-cycle respN_valid pulse with no backpressure.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_sel,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [4:0]       req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_sel,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [4:0]       req1_shamt,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_res,
  output logic             resp_zf,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [4:0]       alu_shamt,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zf,
  output logic             busy
);

  localparam logic [3:0] MUL_M1 = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_M1 = 4'(DIV_CYCLES - 1);

  state_t     state_q, state_d;
  logic       last_grant_q;
  logic       gid_q;
  logic [3:0] count_q;
  logic       gnt;
  logic       gnt_valid;
  logic       accept;
  logic [3:0] sel_in;

  rr_arbiter2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_q),
    .grant       (gnt),
    .grant_valid (gnt_valid)
  );

  assign sel_in = gnt ? req1_sel : req0_sel;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        accept     = gnt_valid;
        req0_ready = gnt_valid && !gnt;
        req1_ready = gnt_valid && gnt;
        if (gnt_valid) state_d = EXEC;
      end
      EXEC: begin
        if (count_q == 4'd0) state_d = DONE;
      end
      DONE: begin
        resp0_valid = !gid_q;
        resp1_valid = gid_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      count_q      <= 4'd0;
      alu_x        <= '0;
      alu_y        <= '0;
      alu_shamt    <= '0;
      alu_sel      <= '0;
      resp_res     <= '0;
      resp_zf      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_sel   <= sel_in;
        alu_x     <= gnt ? req1_x : req0_x;
        alu_y     <= gnt ? req1_y : req0_y;
        alu_shamt <= gnt ? req1_shamt : req0_shamt;
        gid_q     <= gnt;
        count_q   <= hold_count(sel_in, MUL_M1, DIV_M1);
      end else if (state_q == EXEC && count_q != 4'd0) begin
        count_q <= count_q - 4'd1;
      end
      // Last EXEC cycle: the multicycle path has had k cycles to settle.
      if (state_q == EXEC && count_q == 4'd0) begin
        resp_res <= alu_res;
        resp_zf  <= alu_zf;
      end
      if (state_q == DONE) last_grant_q <= gid_q;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU closes the loop, and a
// transaction-level model predicts grant order, latency and results.
module tb_alu_share_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_sel, req1_sel;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [4:0]   req0_shamt, req1_shamt;
  logic         resp0_valid, resp1_valid;
  logic [W-1:0] resp_res;
  logic         resp_zf;
  logic [W-1:0] alu_x, alu_y;
  logic [4:0]   alu_shamt;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_res;
  logic         alu_zf;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  alu_share_ctrl #(.WIDTH(W), .MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_x(req0_x), .req0_y(req0_y), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_x(req1_x), .req1_y(req1_y), .req1_shamt(req1_shamt),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_res(resp_res), .resp_zf(resp_zf),
    .alu_x(alu_x), .alu_y(alu_y), .alu_shamt(alu_shamt), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_zf(alu_zf), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU: {zf, result} ----------------
  function automatic logic [W:0] alu_f(input logic [3:0] s, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [4:0] sh);
    logic [W-1:0] r;
    case (s)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = (b == 0) ? '1 : a / b;
      4'd4:    r = a & b;
      4'd5:    r = a | b;
      4'd6:    r = ~(a | b);
      4'd7:    r = a << sh;
      4'd8:    r = a >> sh;
      4'd9:    r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd10:   r = a ^ b;
      default: r = '0;
    endcase
    return {(r == 0), r};
  endfunction

  always_comb {alu_zf, alu_res} = alu_f(alu_sel, alu_x, alu_y, alu_shamt);

  function automatic int k_of(input logic [3:0] s);
    if (s == 4'd2) return 4;
    if (s == 4'd3) return 8;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_sel = 0; req0_x = 0; req0_y = 0; req0_shamt = 0;
    req1_sel = 0; req1_x = 0; req1_y = 0; req1_shamt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  // Issue one op on one port, then check timing, port and payload of the reply.
  task automatic do_op(input bit port, input logic [3:0] s, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [4:0] sh);
    int n;
    int lat;
    int k;
    logic [W:0] e;
    k = k_of(s);
    exp_q.push_back(alu_f(s, x, y, sh));
    @(posedge clk); #1;
    if (port) begin req1_valid = 1; req1_sel = s; req1_x = x; req1_y = y; req1_shamt = sh; end
    else      begin req0_valid = 1; req0_sel = s; req0_x = x; req0_y = y; req0_shamt = sh; end
    n = 0;
    forever begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) break;
      n++;
      if (n > 50) begin
        chk("ready_timeout", 1, 0);
        idle_inputs();
        void'(exp_q.pop_front());
        return;
      end
    end
    chk("other_ready_low", port ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    // Scramble inputs while busy; they must be ignored.
    idle_inputs();
    req0_x = $urandom; req1_x = $urandom; req0_sel = 4'($urandom); req1_sel = 4'($urandom);
    @(negedge clk);
    chk("alu_sel", alu_sel, s);
    chk("alu_x", alu_x, x);
    chk("alu_y", alu_y, y);
    chk("alu_shamt", alu_shamt, sh);
    lat = 1;
    while (!(resp0_valid || resp1_valid) && lat < 40) begin
      if (busy !== 1'b1 || req0_ready || req1_ready) chk("busy_window", {busy, req0_ready, req1_ready}, 3'b100);
      @(negedge clk); lat++;
    end
    e = exp_q.pop_front();
    chk("latency", lat, k + 1);
    chk("busy_in_done", busy, 1);
    chk("resp_port", {resp1_valid, resp0_valid}, port ? 2 : 1);
    chk("resp_res", resp_res, e[W-1:0]);
    chk("resp_zf", resp_zf, e[W]);
    @(negedge clk);
    chk("pulse_one_cycle", {resp1_valid, resp0_valid, busy}, 0);
    idle_inputs();
  endtask

  // Both ports request AND continuously; returns acceptance cycle per port.
  task automatic contend(output int t0, output int t1);
    int t;
    t0 = -1; t1 = -1; t = 0;
    @(posedge clk); #1;
    req0_valid = 1; req0_sel = 4'd4; req0_x = 32'hF0F0; req0_y = 32'h0FF0;
    req1_valid = 1; req1_sel = 4'd4; req1_x = 32'hAAAA; req1_y = 32'hFFFF;
    while ((t0 < 0 || t1 < 0) && t < 30) begin
      @(negedge clk);
      if (req0_ready && req1_ready) chk("both_ready", 1, 0);
      if (req0_ready) t0 = t;
      if (req1_ready) t1 = t;
      @(posedge clk); #1;
      if (t0 == t) req0_valid = 0;
      if (t1 == t) req1_valid = 0;
      t++;
    end
    idle_inputs();
    repeat (4) @(posedge clk);
  endtask

  typedef struct {
    bit         port;
    logic [3:0] sel;
    logic [W-1:0] x, y;
    logic [4:0] sh;
    logic [W-1:0] exp_res;
    logic         exp_zf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t0, t1, lat;
    bit seen;
    vecs[0] = '{0, 4'd0,  32'd5,   32'd7,  5'd0, 32'd12,         1'b0};
    vecs[1] = '{1, 4'd1,  32'd9,   32'd9,  5'd0, 32'd0,          1'b1};
    vecs[2] = '{0, 4'd2,  32'd6,   32'd7,  5'd0, 32'd42,         1'b0};
    vecs[3] = '{0, 4'd3,  32'd100, 32'd7,  5'd0, 32'd14,         1'b0};
    vecs[4] = '{1, 4'd15, 32'd33,  32'd44, 5'd3, 32'd0,          1'b1};
    vecs[5] = '{1, 4'd7,  32'd1,   32'd0,  5'd31, 32'h8000_0000, 1'b0};
    vecs[6] = '{0, 4'd9,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1,     1'b0};
    vecs[7] = '{1, 4'd6,  32'hFFFF_0000, 32'h0000_FFFF, 5'd0, 32'd0, 1'b1};

    rst = 1; idle_inputs();
    repeat (2) @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ready", {req0_ready, req1_ready}, 0);
    chk("reset_resp", {resp0_valid, resp1_valid, resp_zf}, 0);
    chk("reset_res", resp_res, 0);
    chk("reset_alu", {alu_sel, alu_shamt}, 0);
    chk("reset_alu_x", alu_x, 0);

    // Table vectors: bench-side constants confirm the behavioural ALU too.
    for (int i = 0; i < 8; i++) begin
      chk("vec_model", alu_f(vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].sh),
          {vecs[i].exp_zf, vecs[i].exp_res});
      do_op(vecs[i].port, vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].sh);
    end

    // Contention: fresh reset means req0 first; req1 follows after k+2=3.
    do_reset();
    contend(t0, t1);
    chk("rr_first_t0", t0, 0);
    chk("rr_first_t1", t1, 3);
    contend(t0, t1);
    chk("rr_second_t0", t0, 0);
    chk("rr_second_t1", t1, 3);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    req0_valid = 1; req0_sel = 4'd2; req0_x = 6; req0_y = 7;
    @(negedge clk);
    chk("mid_rst_ready", req0_ready, 1);
    @(posedge clk); #1 idle_inputs();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu", {alu_sel, alu_shamt}, 0);
    chk("mid_rst_alu_x", alu_x, 0);
    chk("mid_rst_res", {resp_res, resp_zf}, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid || busy) seen = 1;
    end
    chk("mid_rst_no_pulse", seen, 0);
    do_op(0, 4'd0, 32'd1, 32'd1, 5'd0);

    // Randomized ops against the behavioural model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] s;
      logic [W-1:0] x, y;
      s = 4'($urandom_range(0, 15));
      x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
      y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 5) == 0) y = x;
      do_op(1'($urandom_range(0, 1)), s, x, y, 5'($urandom_range(0, 31)));
    end

    lat = exp_q.size();
    chk("queue_empty", lat, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
